fib_sweep_ctrl: RTL
===================

# fib_sweep_ctrl

Sequencing controller for the 4-bit Fibonacci detectors (behavioural "B" and gate-level "G" variants). On `start` it sweeps every input code through both detectors, waits a programmable settle time, and samples both outputs. It compares each sample against an internally generated Fibonacci golden sequence and reports pass/fail, the first failing code and accumulated statistics. It replaces the open-loop bench sweep with a synthesizable on-chip self-check.

## Interface
- `N`, 4, detector input width; the sweep covers codes 0 .. 2^N-1
- `SETTLE`, 2, cycles `dut_i` is held before sampling; legal range 1..15
- `STOP_ON_FAIL`, 1, 1 = end the sweep at the first mismatch; 0 = complete the sweep

- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a sweep when idle or done
- `abort`  in  1  level; returns the controller to IDLE from any state
- `dut_i`  out  N  code driven to both detectors
- `o_b`  in  1  output of detector B
- `o_g`  in  1  output of detector G
- `busy`  out  1  high while a sweep is in progress
- `done`  out  1  high from sweep completion until the next `start`, `abort` or reset
- `pass`  out  1  valid while `done`; 1 = no mismatch on either detector
- `fail_idx`  out  N  first code that mismatched; 0 if none
- `fail_src`  out  2  at `fail_idx`: bit0 = B wrong, bit1 = G wrong
- `err_count`  out  N+1  number of codes on which B or G mismatched
- `hit_mask`  out  2^N  bit k = golden result for code k, accumulated during the sweep

## Operation
- States: IDLE, DRIVE, CHECK, ADV, DONE.
- **Reset.** The reset values are: state IDLE, `dut_i` 0, `busy` 0, `done` 0, `pass` 0, `fail_idx` 0, `fail_src` 0, `err_count` 0, `hit_mask` 0.
- **IDLE or DONE, on `start`.**
  - Set x=0 and settle counter=0.
  - Set golden pair a=0, b=1.
  - Clear `err_count`, `hit_mask`, `fail_*` and `done`.
  - Go to DRIVE.
- **DRIVE.**
  - `dut_i`=x and `busy`=1.
  - The counter increments each cycle.
  - When counter == SETTLE-1, go to CHECK.
- **CHECK (one cycle).**
  - g = (a == x), where a is compared zero-extended.
  - Set `hit_mask[x]`=g.
  - eb = o_b≠g and eg = o_g≠g.
  - If eb|eg:
    - `err_count` increments.
    - If this is the first error, latch `fail_idx`=x and `fail_src`={eg,eb}.
  - Go to ADV.
- **ADV.** Each cycle, evaluate the following in order:
  - If a ≤ x: update a←b and b←a+b, then stay in ADV.
  - Else, if (error seen and STOP_ON_FAIL) or x == 2^N-1: go to DONE.
  - Else: x←x+1, counter←0, go to DRIVE.
- **DONE.**
  - `busy`=0 and `done`=1.
  - `pass` = (`err_count` == 0).
  - `dut_i` holds its last code.
- **Golden width.** a and b are N+2 bits, which is enough for the term after 2^N-1. No saturation is needed.
- **Repeated term.** The duplicate Fibonacci term 1 (a=1 twice) is handled by the ADV loop. Code 1 is reported as a hit exactly once.
- **`start` while busy** is ignored.
- **`abort`** has priority over `start` and all transitions.
  - Next state is IDLE.
  - `busy`=0 and `done`=0.
  - Statistics are retained, but `pass` is forced to 0.
- **Simultaneous `abort` and `start`:** `abort` wins.
- **Asynchronous reset mid-sweep** returns every output to its reset value immediately, independent of `clk`.

## Timing
- `dut_i` changes on the clock edge that enters DRIVE.
- Sampling happens in CHECK, exactly SETTLE cycles after `dut_i` changes.
- Per code, the cost is SETTLE + 1 (CHECK) + ADV cycles.
  - ADV takes 1 + (number of golden advances). For N=4, that is 2 for x=0, 3 for x=1, 1 for non-terminal non-hits.
- `busy` rises on the cycle after `start` is sampled.
- `done` rises on the same edge that `busy` falls.
- Outputs are registered; there is no combinational path from `o_b`/`o_g` to outputs.

## Test plan
- **Reset mid-sweep.**
  - Stimulus: assert `rst_n`=0 while in DRIVE at x=7.
  - Required response: all outputs read 0 asynchronously. After release, the controller stays in IDLE until `start`.
- **Correct detectors.**
  - Stimulus: both detectors modelled correctly; `start`.
  - Required response: `done`=1, `pass`=1, `err_count`=0, `hit_mask`=16'h212F, `fail_idx`=0, `fail_src`=0.
- **G stuck-at-0, STOP_ON_FAIL=1.**
  - Stimulus: G output stuck at 0; `start`.
  - Required response: DONE after code 0, with `fail_idx`=0, `fail_src`=2'b10, `err_count`=1, `pass`=0.
- **B inverted at code 8 only, STOP_ON_FAIL=0.**
  - Required response: the full sweep completes, with `fail_idx`=8, `fail_src`=2'b01, `err_count`=1, `hit_mask`=16'h212F.
- **Settle-time check, SETTLE=3.**
  - Stimulus: a detector model with 2-cycle output delay.
  - Required response: `pass`=1, and `dut_i` is held 3 cycles per code.
- **Abort and ignored start.**
  - Stimulus: `abort` at x=5; then `start` while `busy`.
  - Required response: after `abort`, IDLE with `busy`=0, `done`=0, `pass`=0. Restart behaves as in the correct-detectors case. A `start` pulse during `busy` has no effect on x.

Source files
------------

// File: rtl/fib_sweep_ctrl.sv
// rtl/fib_sweep_ctrl.sv - on-chip sweep and self-check of two Fibonacci detectors
// Drives every code to both detectors, samples after a settle time, compares with a running Fibonacci pair.
module fib_sweep_ctrl #(
  parameter int N            = 4,
  parameter int SETTLE       = 2,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N-1:0]         dut_i,
  input  logic                 o_b,
  input  logic                 o_g,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N-1:0]         fail_idx,
  output logic [1:0]           fail_src,
  output logic [N:0]           err_count,
  output logic [(1<<N)-1:0]    hit_mask
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_CHECK, S_ADV, S_DONE} state_t;

  localparam logic [3:0]   LP_SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [N-1:0] LP_X_MAX     = '1;

  state_t              r_state;
  state_t              w_next;
  logic [N-1:0]        r_x;
  logic [3:0]          r_cnt;
  logic [N+1:0]        r_a;
  logic [N+1:0]        r_b;
  logic [N-1:0]        r_fail_idx;
  logic [1:0]          r_fail_src;
  logic [N:0]          r_err_count;
  logic [(1<<N)-1:0]   r_hit_mask;

  logic [N+1:0]        w_x_ext;
  logic                w_a_le_x;
  logic                w_g;
  logic                w_eb;
  logic                w_eg;
  logic                w_err_seen;
  logic                w_stop;

  assign w_x_ext    = {2'b00, r_x};
  assign w_a_le_x   = (r_a <= w_x_ext);
  assign w_g        = (r_a == w_x_ext);
  assign w_eb       = o_b ^ w_g;
  assign w_eg       = o_g ^ w_g;
  assign w_err_seen = (r_err_count != '0);
  assign w_stop     = (STOP_ON_FAIL && w_err_seen) || (r_x == LP_X_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ADV keeps stepping the golden pair until it passes x, so repeated terms are absorbed here
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_DRIVE;
      S_DRIVE:        if (r_cnt == LP_SETTLE_M1) w_next = S_CHECK;
      S_CHECK:        w_next = S_ADV;
      S_ADV:          if (!w_a_le_x) w_next = w_stop ? S_DONE : S_DRIVE;
      default:        w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    busy      = (r_state == S_DRIVE) || (r_state == S_CHECK) || (r_state == S_ADV);
    done      = (r_state == S_DONE);
    pass      = (r_state == S_DONE) && !w_err_seen;
    dut_i     = r_x;
    fail_idx  = r_fail_idx;
    fail_src  = r_fail_src;
    err_count = r_err_count;
    hit_mask  = r_hit_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= (N+2)'(1);
      r_fail_idx  <= '0;
      r_fail_src  <= '0;
      r_err_count <= '0;
      r_hit_mask  <= '0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_x         <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= (N+2)'(1);
            r_fail_idx  <= '0;
            r_fail_src  <= '0;
            r_err_count <= '0;
            r_hit_mask  <= '0;
          end
        end
        S_DRIVE: r_cnt <= r_cnt + 4'd1;
        S_CHECK: begin
          r_hit_mask[r_x] <= w_g;
          if (w_eb || w_eg) begin
            r_err_count <= r_err_count + (N+1)'(1);
            if (!w_err_seen) begin
              r_fail_idx <= r_x;
              r_fail_src <= {w_eg, w_eb};
            end
          end
        end
        S_ADV: begin
          if (w_a_le_x) begin
            r_a <= r_b;
            r_b <= r_a + r_b;
          end else if (!w_stop) begin
            r_x   <= r_x + N'(1);
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
